// File: rtl/axil_host_initiator.sv
// -----------------------------------------------------------------------------
// axil_host_initiator
//
// Turns single-beat host commands into complete AXI-Lite read or write
// transactions on a master port. The read data and the response code come back
// on a separate response channel. A per-transaction cycle budget turns a hung
// slave into an error response, so the host is never stalled forever.
//
// Ports
//   clk_i, rst_ni          : single clock, asynchronous active-low reset
//   cmd_*                  : host command channel (valid/ready, write flag,
//                            byte address, write data, write strobes)
//   rsp_*                  : host response channel (valid/ready, read data,
//                            BRESP/RRESP or 2'b11 on timeout, timeout flag)
//   m_aw*, m_w*, m_b*      : AXI-Lite write address / data / response channels
//   m_ar*, m_r*            : AXI-Lite read address / data channels
//
// Every output is registered except cmd_ready_o, which is decoded from state.
// -----------------------------------------------------------------------------
module axil_host_initiator #(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // host command channel
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_wstrb_i,
  // host response channel
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic [1:0]          rsp_resp_o,
  output logic                rsp_timeout_o,
  // AXI-Lite write address channel
  output logic                m_awvalid_o,
  input  logic                m_awready_i,
  output logic [ADDR_W-1:0]   m_awaddr_o,
  output logic [2:0]          m_awprot_o,
  // AXI-Lite write data channel
  output logic                m_wvalid_o,
  input  logic                m_wready_i,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  // AXI-Lite write response channel
  input  logic                m_bvalid_i,
  output logic                m_bready_o,
  input  logic [1:0]          m_bresp_i,
  // AXI-Lite read address channel
  output logic                m_arvalid_o,
  input  logic                m_arready_i,
  output logic [ADDR_W-1:0]   m_araddr_o,
  output logic [2:0]          m_arprot_o,
  // AXI-Lite read data channel
  input  logic                m_rvalid_i,
  output logic                m_rready_o,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic [1:0]          m_rresp_i
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_e;

  state_e              state_q, state_d;

  logic                awvalid_q, awvalid_d;
  logic                wvalid_q,  wvalid_d;
  logic                bready_q,  bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q,  rready_d;
  logic [ADDR_W-1:0]   awaddr_q,  awaddr_d;
  logic [ADDR_W-1:0]   araddr_q,  araddr_d;
  logic [DATA_W-1:0]   wdata_q,   wdata_d;
  logic [STRB_W-1:0]   wstrb_q,   wstrb_d;

  logic                rsp_valid_q,   rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q,   rsp_rdata_d;
  logic [1:0]          rsp_resp_q,    rsp_resp_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  logic                cmd_fire_s;
  logic                bus_state_s;
  logic                aw_done_s;
  logic                w_done_s;
  logic                step_done_s;
  logic                expire_s;
  logic                abort_s;

  assign cmd_fire_s  = cmd_valid_i && (state_q == IDLE);
  assign bus_state_s = (state_q == WR_REQ)  || (state_q == WR_RESP) ||
                       (state_q == RD_REQ)  || (state_q == RD_RESP);

  // A write channel counts as done if its valid already dropped after an
  // earlier handshake, or if the handshake happens this cycle.
  assign aw_done_s = !awvalid_q || m_awready_i;
  assign w_done_s  = !wvalid_q  || m_wready_i;

  // Whether the step the FSM is waiting on completes in the current cycle.
  always_comb begin
    step_done_s = 1'b0;
    case (state_q)
      WR_REQ:  step_done_s = aw_done_s && w_done_s;
      WR_RESP: step_done_s = m_bvalid_i;
      RD_REQ:  step_done_s = m_arready_i;
      RD_RESP: step_done_s = m_rvalid_i;
      default: step_done_s = 1'b0;
    endcase
  end

  // A handshake on the expiry cycle wins over the timeout.
  assign abort_s = expire_s && !step_done_s;

  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam int unsigned       CNT_W = $clog2(TIMEOUT + 1);
      localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Per-transaction bus-cycle counter, cleared when a command is taken.
      always_comb begin
        cnt_d = cnt_q;
        if (cmd_fire_s) begin
          cnt_d = '0;
        end else if (bus_state_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end

      // Counter register.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // The counter holds TIMEOUT-1 during the TIMEOUT-th bus cycle.
      assign expire_s = bus_state_s && (cnt_q == LAST);
    end else begin : g_no_timeout
      assign expire_s = 1'b0;
    end
  endgenerate

  // Next-state and next-output decode for the transaction FSM.
  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    awaddr_d      = awaddr_q;
    araddr_d      = araddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_write_i) begin
            awaddr_d  = cmd_addr_i;
            wdata_d   = cmd_wdata_i;
            wstrb_d   = cmd_wstrb_i;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            araddr_d  = cmd_addr_i;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end

      WR_REQ: begin
        if (aw_done_s && w_done_s) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = WR_RESP;
        end else begin
          // AW and W are independent: each valid drops on its own handshake.
          awvalid_d = awvalid_q && !m_awready_i;
          wvalid_d  = wvalid_q  && !m_wready_i;
        end
      end

      WR_RESP: begin
        if (m_bvalid_i) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = m_bresp_i;
          rsp_timeout_d = 1'b0;
          state_d       = RSP;
        end else begin
          state_d = WR_RESP;
        end
      end

      RD_REQ: begin
        if (m_arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end else begin
          state_d = RD_REQ;
        end
      end

      RD_RESP: begin
        if (m_rvalid_i) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = m_rdata_i;
          rsp_resp_d    = m_rresp_i;
          rsp_timeout_d = 1'b0;
          state_d       = RSP;
        end else begin
          state_d = RD_RESP;
        end
      end

      RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RSP;
        end
      end

      default: begin
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    // Timeout abort overrides whatever the bus state decided: every master
    // valid/ready drops and an error response is queued to the host. Late
    // slave responses are deliberately left unconsumed.
    if (abort_s) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = 2'b11;
      rsp_timeout_d = 1'b1;
      state_d       = RSP;
    end else begin
      // No abort: the decisions made by the state decode stand.
    end
  end

  // State and registered-output flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      awaddr_q      <= awaddr_d;
      araddr_q      <= araddr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready_o   = (state_q == IDLE);

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_resp_o    = rsp_resp_q;
  assign rsp_timeout_o = rsp_timeout_q;

  assign m_awvalid_o   = awvalid_q;
  assign m_awaddr_o    = awaddr_q;
  assign m_awprot_o    = 3'b000;
  assign m_wvalid_o    = wvalid_q;
  assign m_wdata_o     = wdata_q;
  assign m_wstrb_o     = wstrb_q;
  assign m_bready_o    = bready_q;
  assign m_arvalid_o   = arvalid_q;
  assign m_araddr_o    = araddr_q;
  assign m_arprot_o    = 3'b000;
  assign m_rready_o    = rready_q;

endmodule

// File: tb/tb_axil_host_initiator.sv
// -----------------------------------------------------------------------------
// tb_axil_host_initiator
//
// Self-checking bench for axil_host_initiator (TIMEOUT set to 16). Each task
// scripts one scenario cycle by cycle, acting as the AXI-Lite slave, and
// compares DUT outputs one time unit after the rising edge. Expected host
// responses are pushed to a scoreboard queue when a command is issued and
// popped when the DUT presents its response.
// -----------------------------------------------------------------------------
module tb_axil_host_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [19:0] cmd_addr = 20'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic [3:0]  cmd_wstrb = 4'h0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        m_awvalid, m_awready = 1'b0;
  logic [19:0] m_awaddr;
  logic [2:0]  m_awprot;
  logic        m_wvalid, m_wready = 1'b0;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_bvalid = 1'b0, m_bready;
  logic [1:0]  m_bresp = 2'b00;
  logic        m_arvalid, m_arready = 1'b0;
  logic [19:0] m_araddr;
  logic [2:0]  m_arprot;
  logic        m_rvalid = 1'b0, m_rready;
  logic [31:0] m_rdata = 32'h0;
  logic [1:0]  m_rresp = 2'b00;

  always #5 clk = ~clk;

  axil_host_initiator #(.ADDR_W(20), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_resp_o(rsp_resp), .rsp_timeout_o(rsp_timeout),
    .m_awvalid_o(m_awvalid), .m_awready_i(m_awready), .m_awaddr_o(m_awaddr), .m_awprot_o(m_awprot),
    .m_wvalid_o(m_wvalid), .m_wready_i(m_wready), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb),
    .m_bvalid_i(m_bvalid), .m_bready_o(m_bready), .m_bresp_i(m_bresp),
    .m_arvalid_o(m_arvalid), .m_arready_i(m_arready), .m_araddr_o(m_araddr), .m_arprot_o(m_arprot),
    .m_rvalid_i(m_rvalid), .m_rready_o(m_rready), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } rsp_t;

  rsp_t sb[$];
  rsp_t got_r;
  assign got_r = {rsp_rdata, rsp_resp, rsp_timeout};

  // Control bits: {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}
  logic [6:0] ctl;
  assign ctl = {cmd_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid};

  localparam logic [6:0] C_IDLE = 7'b1000000;
  localparam logic [6:0] C_WREQ = 7'b0110000;
  localparam logic [6:0] C_AWON = 7'b0100000;
  localparam logic [6:0] C_WRSP = 7'b0001000;
  localparam logic [6:0] C_RREQ = 7'b0000100;
  localparam logic [6:0] C_RRSP = 7'b0000010;
  localparam logic [6:0] C_RSP  = 7'b0000001;

  int n_vec = 0;
  int n_err = 0;
  int b_hs  = 0;
  int rv_cnt = 0;

  // Event counters on the DUT's handshakes.
  always @(posedge clk) begin
    if (m_bvalid && m_bready) b_hs <= b_hs + 1;
    if (rsp_valid) rv_cnt <= rv_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [19:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
  endtask

  task automatic slave_idle();
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    slave_idle();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (ctl !== C_IDLE) begin n_err++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_IDLE); end
    n_vec++; if ({m_awaddr, m_araddr, m_wdata, m_wstrb, m_awprot, m_arprot} !== 82'h0) begin
      n_err++; $display("FAIL reset_payload: got %h expected 0", {m_awaddr, m_araddr, m_wdata, m_wstrb, m_awprot, m_arprot}); end
    n_vec++; if (got_r !== 35'h0) begin n_err++; $display("FAIL reset_rsp: got %h expected 0", got_r); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_basic();
    rsp_t e;
    int b0;
    b0 = b_hs;
    sb.push_back({32'h0, 2'b00, 1'b0});
    m_awready = 1'b1; m_wready = 1'b1;
    issue(1'b1, 20'h00010, 32'hDEADBEEF, 4'hF);
    n_vec++; if (ctl !== C_IDLE) begin n_err++; $display("FAIL wr_c0_ctl: got %b expected %b", ctl, C_IDLE); end
    tick(); cmd_valid = 1'b0;
    n_vec++; if (ctl !== C_WREQ) begin n_err++; $display("FAIL wr_c1_ctl: got %b expected %b", ctl, C_WREQ); end
    n_vec++; if ({m_awaddr, m_wdata, m_wstrb, m_awprot} !== {20'h00010, 32'hDEADBEEF, 4'hF, 3'b000}) begin
      n_err++; $display("FAIL wr_c1_payload: got %h expected %h", {m_awaddr, m_wdata, m_wstrb, m_awprot}, {20'h00010, 32'hDEADBEEF, 4'hF, 3'b000}); end
    tick(); m_awready = 1'b0; m_wready = 1'b0;
    n_vec++; if (ctl !== C_WRSP) begin n_err++; $display("FAIL wr_c2_ctl: got %b expected %b", ctl, C_WRSP); end
    m_bvalid = 1'b1; m_bresp = 2'b00;
    tick(); m_bvalid = 1'b0;
    n_vec++; if (ctl !== C_RSP) begin n_err++; $display("FAIL wr_c3_ctl: got %b expected %b", ctl, C_RSP); end
    e = sb.pop_front();
    n_vec++; if (got_r !== e) begin n_err++; $display("FAIL wr_rsp: got %h expected %h", got_r, e); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    n_vec++; if (ctl !== C_IDLE) begin n_err++; $display("FAIL wr_c4_ctl: got %b expected %b", ctl, C_IDLE); end
    n_vec++; if (b_hs - b0 !== 1) begin n_err++; $display("FAIL wr_bcount: got %0d expected 1", b_hs - b0); end
  endtask

  task automatic test_write_w_first();
    rsp_t e;
    int b0;
    b0 = b_hs;
    sb.push_back({32'h0, 2'b00, 1'b0});
    m_wready = 1'b1;
    issue(1'b1, 20'h00A4C, 32'hCAFEF00D, 4'b0101);
    tick(); cmd_valid = 1'b0;
    n_vec++; if (ctl !== C_WREQ) begin n_err++; $display("FAIL wf_c1_ctl: got %b expected %b", ctl, C_WREQ); end
    tick(); m_wready = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      n_vec++; if (ctl !== C_AWON) begin n_err++; $display("FAIL wf_hold_ctl c%0d: got %b expected %b", i, ctl, C_AWON); end
      n_vec++; if (m_awaddr !== 20'h00A4C) begin n_err++; $display("FAIL wf_hold_addr c%0d: got %h expected 00a4c", i, m_awaddr); end
      if (i == 4) m_awready = 1'b1;
      tick();
    end
    m_awready = 1'b0;
    n_vec++; if (ctl !== C_WRSP) begin n_err++; $display("FAIL wf_bresp_ctl: got %b expected %b", ctl, C_WRSP); end
    m_bvalid = 1'b1;
    tick();
    n_vec++; if (ctl !== C_RSP) begin n_err++; $display("FAIL wf_rsp_ctl: got %b expected %b", ctl, C_RSP); end
    e = sb.pop_front();
    n_vec++; if (got_r !== e) begin n_err++; $display("FAIL wf_rsp: got %h expected %h", got_r, e); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0; m_bvalid = 1'b0;
    n_vec++; if (ctl !== C_IDLE) begin n_err++; $display("FAIL wf_idle_ctl: got %b expected %b", ctl, C_IDLE); end
    n_vec++; if (b_hs - b0 !== 1) begin n_err++; $display("FAIL wf_bcount: got %0d expected 1", b_hs - b0); end
  endtask

  task automatic test_read_delay();
    rsp_t e;
    sb.push_back({32'h12345678, 2'b00, 1'b0});
    issue(1'b0, 20'h00020, 32'h0, 4'h0);
    tick(); cmd_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      n_vec++; if (ctl !== C_RREQ) begin n_err++; $display("FAIL rd_ar_ctl c%0d: got %b expected %b", i, ctl, C_RREQ); end
      n_vec++; if ({m_araddr, m_arprot} !== {20'h00020, 3'b000}) begin
        n_err++; $display("FAIL rd_ar_addr c%0d: got %h expected %h", i, {m_araddr, m_arprot}, {20'h00020, 3'b000}); end
      if (i == 3) m_arready = 1'b1;
      tick();
    end
    m_arready = 1'b0;
    for (int i = 4; i <= 9; i++) begin
      n_vec++; if (ctl !== C_RRSP) begin n_err++; $display("FAIL rd_r_ctl c%0d: got %b expected %b", i, ctl, C_RRSP); end
      if (i == 9) begin m_rvalid = 1'b1; m_rdata = 32'h12345678; m_rresp = 2'b00; end
      tick();
    end
    m_rvalid = 1'b0; m_rdata = 32'h0;
    n_vec++; if (ctl !== C_RSP) begin n_err++; $display("FAIL rd_rsp_ctl: got %b expected %b", ctl, C_RSP); end
    e = sb.pop_front();
    n_vec++; if (got_r !== e) begin n_err++; $display("FAIL rd_rsp: got %h expected %h", got_r, e); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    n_vec++; if (ctl !== C_IDLE) begin n_err++; $display("FAIL rd_idle_ctl: got %b expected %b", ctl, C_IDLE); end
  endtask

  task automatic test_read_slverr();
    rsp_t e;
    sb.push_back({32'hDEC0DE00, 2'b10, 1'b0});
    m_arready = 1'b1;
    issue(1'b0, 20'h0FFFC, 32'h0, 4'h0);
    tick(); cmd_valid = 1'b0;
    n_vec++; if (ctl !== C_RREQ) begin n_err++; $display("FAIL se_c1_ctl: got %b expected %b", ctl, C_RREQ); end
    tick(); m_arready = 1'b0;
    n_vec++; if (ctl !== C_RRSP) begin n_err++; $display("FAIL se_c2_ctl: got %b expected %b", ctl, C_RRSP); end
    m_rvalid = 1'b1; m_rdata = 32'hDEC0DE00; m_rresp = 2'b10;
    tick(); m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
    e = sb.pop_front();
    n_vec++; if (got_r !== e) begin n_err++; $display("FAIL se_rsp: got %h expected %h", got_r, e); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    rsp_t e;
    // AW never accepted: abort after 16 bus cycles.
    sb.push_back({32'h0, 2'b11, 1'b1});
    m_wready = 1'b1;
    issue(1'b1, 20'h00100, 32'h01020304, 4'hF);
    tick(); cmd_valid = 1'b0;
    n_vec++; if (ctl !== C_WREQ) begin n_err++; $display("FAIL to_c1_ctl: got %b expected %b", ctl, C_WREQ); end
    tick(); m_wready = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      n_vec++; if (ctl !== C_AWON) begin n_err++; $display("FAIL to_hold_ctl c%0d: got %b expected %b", i, ctl, C_AWON); end
      tick();
    end
    n_vec++; if (ctl !== C_RSP) begin n_err++; $display("FAIL to_abort_ctl: got %b expected %b", ctl, C_RSP); end
    e = sb.pop_front();
    n_vec++; if (got_r !== e) begin n_err++; $display("FAIL to_rsp: got %h expected %h", got_r, e); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    // B arrives on the 16th bus cycle: the handshake wins.
    sb.push_back({32'h0, 2'b00, 1'b0});
    m_awready = 1'b1; m_wready = 1'b1;
    issue(1'b1, 20'h00104, 32'h05060708, 4'hF);
    tick(); cmd_valid = 1'b0;
    tick(); m_awready = 1'b0; m_wready = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      n_vec++; if (ctl !== C_WRSP) begin n_err++; $display("FAIL tb_wait_ctl c%0d: got %b expected %b", i, ctl, C_WRSP); end
      if (i == 16) m_bvalid = 1'b1;
      tick();
    end
    m_bvalid = 1'b0;
    n_vec++; if (ctl !== C_RSP) begin n_err++; $display("FAIL tb_rsp_ctl: got %b expected %b", ctl, C_RSP); end
    e = sb.pop_front();
    n_vec++; if (got_r !== e) begin n_err++; $display("FAIL tb_rsp: got %h expected %h", got_r, e); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_rsp_backpressure();
    rsp_t e;
    sb.push_back({32'hA5A55A5A, 2'b01, 1'b0});
    m_arready = 1'b1;
    issue(1'b0, 20'h00040, 32'h0, 4'h0);
    tick(); cmd_valid = 1'b0;
    tick(); m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'hA5A55A5A; m_rresp = 2'b01;
    tick(); m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
    issue(1'b1, 20'h00044, 32'hFFFFFFFF, 4'hF);
    for (int i = 0; i < 10; i++) begin
      n_vec++; if (ctl !== C_RSP) begin n_err++; $display("FAIL bp_ctl cyc%0d: got %b expected %b", i, ctl, C_RSP); end
      n_vec++; if (got_r !== sb[0]) begin n_err++; $display("FAIL bp_payload cyc%0d: got %h expected %h", i, got_r, sb[0]); end
      tick();
    end
    cmd_valid = 1'b0;
    e = sb.pop_front();
    n_vec++; if (got_r !== e) begin n_err++; $display("FAIL bp_rsp: got %h expected %h", got_r, e); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    n_vec++; if (ctl !== C_IDLE) begin n_err++; $display("FAIL bp_idle_ctl: got %b expected %b", ctl, C_IDLE); end
  endtask

  task automatic test_back_to_back();
    rsp_t        e;
    logic        t_wr   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [19:0] t_addr [4] = '{20'h00004, 20'h00004, 20'h0FFF8, 20'h00008};
    logic [31:0] t_data [4] = '{32'h11112222, 32'h11112222, 32'h33334444, 32'h55556666};
    logic [3:0]  t_strb [4] = '{4'hF, 4'h0, 4'b1000, 4'h0};
    logic [1:0]  t_resp [4] = '{2'b00, 2'b00, 2'b11, 2'b01};
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1; m_bvalid = 1'b1; m_rvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sb.push_back({(t_wr[k] ? 32'h0 : t_data[k]), t_resp[k], 1'b0});
      m_bresp = t_resp[k]; m_rresp = t_resp[k]; m_rdata = t_data[k];
      n_vec++; if (ctl !== C_IDLE) begin n_err++; $display("FAIL b2b_ready cmd%0d: got %b expected %b", k, ctl, C_IDLE); end
      issue(t_wr[k], t_addr[k], t_data[k], t_strb[k]);
      tick(); cmd_valid = 1'b0;
      if (t_wr[k]) begin
        n_vec++; if ({m_awaddr, m_wdata, m_wstrb} !== {t_addr[k], t_data[k], t_strb[k]}) begin
          n_err++; $display("FAIL b2b_wpay cmd%0d: got %h expected %h", k, {m_awaddr, m_wdata, m_wstrb}, {t_addr[k], t_data[k], t_strb[k]}); end
      end else begin
        n_vec++; if (m_araddr !== t_addr[k]) begin n_err++; $display("FAIL b2b_araddr cmd%0d: got %h expected %h", k, m_araddr, t_addr[k]); end
      end
      tick(); tick();
      n_vec++; if (ctl !== C_RSP) begin n_err++; $display("FAIL b2b_rsp_ctl cmd%0d: got %b expected %b", k, ctl, C_RSP); end
      e = sb.pop_front();
      n_vec++; if (got_r !== e) begin n_err++; $display("FAIL b2b_rsp cmd%0d: got %h expected %h", k, got_r, e); end
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    end
    slave_idle();
  endtask

  task automatic test_reset_mid();
    int b0;
    int r0;
    b0 = b_hs;
    m_awready = 1'b1; m_wready = 1'b1;
    issue(1'b1, 20'h00200, 32'h77778888, 4'hF);
    tick(); cmd_valid = 1'b0;
    tick(); m_awready = 1'b0; m_wready = 1'b0;
    n_vec++; if (ctl !== C_WRSP) begin n_err++; $display("FAIL rm_wrsp_ctl: got %b expected %b", ctl, C_WRSP); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (ctl !== C_IDLE) begin n_err++; $display("FAIL rm_async_ctl: got %b expected %b", ctl, C_IDLE); end
    n_vec++; if ({m_awaddr, m_wdata, m_wstrb, got_r} !== 91'h0) begin
      n_err++; $display("FAIL rm_async_payload: got %h expected 0", {m_awaddr, m_wdata, m_wstrb, got_r}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    r0 = rv_cnt;
    m_bvalid = 1'b1;
    repeat (5) tick();
    m_bvalid = 1'b0;
    n_vec++; if (rv_cnt - r0 !== 0) begin n_err++; $display("FAIL rm_no_rsp: got %0d expected 0", rv_cnt - r0); end
    n_vec++; if (b_hs - b0 !== 0) begin n_err++; $display("FAIL rm_no_b: got %0d expected 0", b_hs - b0); end
    n_vec++; if (ctl !== C_IDLE) begin n_err++; $display("FAIL rm_idle_ctl: got %b expected %b", ctl, C_IDLE); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_basic();
    test_write_w_first();
    test_read_delay();
    test_read_slverr();
    test_timeout();
    test_rsp_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
